mem_port_arbiter: RTL and testbench

//  Shares the single data-memory/IO port of the LSU between the pipeline MEM stage (req 0) and a

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles every signal between the MEM stage, the debug/loader master,
//          the LSU and the mem_port_arbiter into one interface.
// Modports:
//   slave  - the arbiter: takes pipeline/debug requests and LSU read data,
//            drives LSU address/data/write-enable, stall, debug grant and read data.
//   master - the surrounding system (pipeline, debug master, LSU model).
// Signals (names keep their direction as seen from the arbiter):
//   pipe_req_i/we_i/addr_i/wdata_i, pipe_rdata_o, stall_o
//   dbg_req_i/we_i/addr_i/wdata_i, dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o
//   lsu_addr_o, lsu_wdata_o, lsu_we_o, lsu_rdata_i
interface mem_port_arbiter_if;
  logic        pipe_req_i;
  logic        pipe_we_i;
  logic [31:0] pipe_addr_i;
  logic [31:0] pipe_wdata_i;
  logic [31:0] pipe_rdata_o;
  logic        stall_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [31:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_gnt_o;
  logic [31:0] dbg_rdata_o;
  logic        dbg_rvalid_o;
  logic [31:0] lsu_addr_o;
  logic [31:0] lsu_wdata_o;
  logic        lsu_we_o;
  logic [31:0] lsu_rdata_i;

  modport slave (
    input  pipe_req_i, pipe_we_i, pipe_addr_i, pipe_wdata_i,
    output pipe_rdata_o, stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o,
    output lsu_addr_o, lsu_wdata_o, lsu_we_o,
    input  lsu_rdata_i
  );

  modport master (
    output pipe_req_i, pipe_we_i, pipe_addr_i, pipe_wdata_i,
    input  pipe_rdata_o, stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o,
    input  lsu_addr_o, lsu_wdata_o, lsu_we_o,
    output lsu_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single LSU data port between the pipeline MEM stage and a
//          debug/loader master. The pipeline has priority; debug uses idle cycles
//          and, after STARVE_LIMIT contended cycles, gets a burst of up to BURST_MAX
//          beats during which the pipeline is stalled.
// Ports:
//   clk_i   - clock, all state updates on posedge
//   rst_ni  - asynchronous active-low reset
//   bus     - mem_port_arbiter_if.slave (pipeline, debug and LSU signals)
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_port_arbiter_if.slave    bus
);

  localparam int WAIT_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BURST_W = (BURST_MAX > 1)    ? $clog2(BURST_MAX)    : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  typedef enum logic {ARB_PIPE, ARB_DBG} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_DBG} owner_e;

  arb_state_e         r_state, w_state_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic [BURST_W-1:0] r_burst_cnt, w_burst_nxt;
  owner_e             w_owner;
  logic               w_stall;
  logic               w_dbg_gnt;
  logic               w_dbg_rd;
  logic               r_dbg_rvalid;
  logic [31:0]        r_dbg_rdata;

  // Owner selection and next-state logic.
  always_comb begin
    w_owner     = OWN_NONE;
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    w_burst_nxt = r_burst_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ARB_PIPE: begin
        if (bus.pipe_req_i)     w_owner = OWN_PIPE;
        else if (bus.dbg_req_i) w_owner = OWN_DBG;
        // Only cycles where debug actually loses to the pipeline count as starvation.
        if (bus.pipe_req_i && bus.dbg_req_i) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ARB_DBG;
            w_wait_nxt  = '0;
            w_burst_nxt = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end
        end
      end
      ARB_DBG: begin
        if (bus.dbg_req_i) begin
          w_owner = OWN_DBG;
          w_stall = bus.pipe_req_i;
          if (r_burst_cnt == BURST_LAST) begin
            w_state_nxt = ARB_PIPE;
            w_burst_nxt = '0;
          end else begin
            w_burst_nxt = r_burst_cnt + 1'b1;
          end
        end else begin
          // Debug went away: the pipeline is served this very cycle, no bubble.
          if (bus.pipe_req_i) w_owner = OWN_PIPE;
          w_state_nxt = ARB_PIPE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ARB_PIPE;
        w_burst_nxt = '0;
      end
    endcase
  end

  assign w_dbg_gnt = (w_owner == OWN_DBG);
  assign w_dbg_rd  = w_dbg_gnt && !bus.dbg_we_i;

  // LSU mux: when nobody owns the port the pipeline address is passed with writes disabled.
  assign bus.lsu_addr_o  = w_dbg_gnt ? bus.dbg_addr_i  : bus.pipe_addr_i;
  assign bus.lsu_wdata_o = w_dbg_gnt ? bus.dbg_wdata_i : bus.pipe_wdata_i;
  assign bus.lsu_we_o    = (w_owner == OWN_PIPE) ? bus.pipe_we_i :
                           (w_owner == OWN_DBG)  ? bus.dbg_we_i  : 1'b0;

  assign bus.pipe_rdata_o = bus.lsu_rdata_i;
  assign bus.stall_o      = w_stall;
  assign bus.dbg_gnt_o    = w_dbg_gnt;
  assign bus.dbg_rdata_o  = r_dbg_rdata;
  assign bus.dbg_rvalid_o = r_dbg_rvalid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ARB_PIPE;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd) r_dbg_rdata <= bus.lsu_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with STARVE_LIMIT=4, BURST_MAX=8, a small word
// memory behind the LSU port and a queue of expected debug read data.
module tb_mem_port_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .BURST_MAX   (8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_exp;
  logic [31:0] tb_mem [0:1023];

  // Word memory; reloaded with a known pattern whenever reset is low.
  assign bus.lsu_rdata_i = tb_mem[bus.lsu_addr_o[11:2]];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= (i == 0) ? 32'h1234 : 32'(32'hA0000 + i);
    end else if (bus.lsu_we_o) begin
      tb_mem[bus.lsu_addr_o[11:2]] <= bus.lsu_wdata_o;
    end
  end

  function automatic logic [31:0] exp_mem(input int idx);
    return (idx == 0) ? 32'h1234 : 32'(32'hA0000 + idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pr, input logic pwe, input logic [31:0] pa, input logic [31:0] pd,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk_i);
    bus.pipe_req_i   = pr;
    bus.pipe_we_i    = pwe;
    bus.pipe_addr_i  = pa;
    bus.pipe_wdata_i = pd;
    bus.dbg_req_i    = dr;
    bus.dbg_we_i     = dwe;
    bus.dbg_addr_i   = da;
    bus.dbg_wdata_i  = dd;
    #1;
  endtask

  // Read-data scoreboard: every rvalid pulse must match the oldest expected value.
  always @(posedge clk_i) begin
    #1;
    if (bus.dbg_rvalid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", {31'b0, bus.dbg_rvalid_o}, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("dbg_rdata", bus.dbg_rdata_o, mon_exp);
      end
    end
  end

  initial begin
    logic        exp_dbg;
    logic [31:0] da;
    rst_ni           = 1'b0;
    bus.pipe_req_i   = 1'b0;
    bus.pipe_we_i    = 1'b0;
    bus.pipe_addr_i  = '0;
    bus.pipe_wdata_i = '0;
    bus.dbg_req_i    = 1'b0;
    bus.dbg_we_i     = 1'b0;
    bus.dbg_addr_i   = '0;
    bus.dbg_wdata_i  = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_stall",  {31'b0, bus.stall_o}, 32'd0);
    chk("rst_gnt",    {31'b0, bus.dbg_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.dbg_rvalid_o}, 32'd0);
    chk("rst_rdata",  bus.dbg_rdata_o, 32'd0);
    rst_ni = 1'b1;

    // T1: pipeline store without debug traffic
    drive(1'b1, 1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_we",    {31'b0, bus.lsu_we_o}, 32'd1);
    chk("t1_addr",  bus.lsu_addr_o, 32'h100);
    chk("t1_wdata", bus.lsu_wdata_o, 32'hDEAD);
    chk("t1_stall", {31'b0, bus.stall_o}, 32'd0);
    chk("t1_gnt",   {31'b0, bus.dbg_gnt_o}, 32'd0);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_load",  bus.pipe_rdata_o, 32'hDEAD);
    chk("t1_ld_we", {31'b0, bus.lsu_we_o}, 32'd0);

    // T2: debug read with pipeline idle, granted immediately
    drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
    chk("t2_gnt",   {31'b0, bus.dbg_gnt_o}, 32'd1);
    chk("t2_addr",  bus.lsu_addr_o, 32'h2000);
    chk("t2_we",    {31'b0, bus.lsu_we_o}, 32'd0);
    chk("t2_stall", {31'b0, bus.stall_o}, 32'd0);
    sb_q.push_back(32'h1234);
    drive(1'b0, 1'b1, 32'h104, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_gnt", {31'b0, bus.dbg_gnt_o}, 32'd0);
    chk("idle_we",  {31'b0, bus.lsu_we_o}, 32'd0);

    // Debug write with pipeline idle, then read it back through the pipeline
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2020, 32'hBEEF);
    chk("dw_gnt",   {31'b0, bus.dbg_gnt_o}, 32'd1);
    chk("dw_we",    {31'b0, bus.lsu_we_o}, 32'd1);
    chk("dw_wdata", bus.lsu_wdata_o, 32'hBEEF);
    drive(1'b1, 1'b0, 32'h2020, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("dw_back",  bus.pipe_rdata_o, 32'hBEEF);

    // T3/T4: both masters held for 20 cycles: 4 pipe, 8 stalled debug, 4 pipe, 4 debug
    for (int k = 1; k <= 20; k++) begin
      da = 32'h2000 + 32'(4 * (k % 8));
      drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, da, 32'h0);
      exp_dbg = (((k - 1) % 12) >= 4);
      chk($sformatf("t34_gnt_%0d", k),   {31'b0, bus.dbg_gnt_o}, {31'b0, exp_dbg});
      chk($sformatf("t34_stall_%0d", k), {31'b0, bus.stall_o},   {31'b0, exp_dbg});
      chk($sformatf("t34_addr_%0d", k),  bus.lsu_addr_o, exp_dbg ? da : 32'h100);
      if (exp_dbg) sb_q.push_back(exp_mem(k % 8));
      else chk($sformatf("t34_load_%0d", k), bus.pipe_rdata_o, 32'hDEAD);
    end

    // T5: debug drops mid-burst, pipeline takes the port in the same cycle
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h2000, 32'h0);
    chk("t5_gnt",   {31'b0, bus.dbg_gnt_o}, 32'd0);
    chk("t5_stall", {31'b0, bus.stall_o}, 32'd0);
    chk("t5_addr",  bus.lsu_addr_o, 32'h100);
    chk("t5_load",  bus.pipe_rdata_o, 32'hDEAD);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0);
      exp_dbg = (k >= 5);
      chk($sformatf("t5_gnt_%0d", k),   {31'b0, bus.dbg_gnt_o}, {31'b0, exp_dbg});
      chk($sformatf("t5_stall_%0d", k), {31'b0, bus.stall_o},   {31'b0, exp_dbg});
      if (exp_dbg) sb_q.push_back(exp_mem(1));
    end

    // T6: reset asserted while a debug read beat is being granted
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0);
    chk("t6_pre_gnt", {31'b0, bus.dbg_gnt_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_stall",  {31'b0, bus.stall_o}, 32'd0);
    chk("t6_gnt",    {31'b0, bus.dbg_gnt_o}, 32'd0);
    chk("t6_rvalid", {31'b0, bus.dbg_rvalid_o}, 32'd0);
    chk("t6_rdata",  bus.dbg_rdata_o, 32'd0);
    @(negedge clk_i);
    #1;
    chk("t6_hold_rvalid", {31'b0, bus.dbg_rvalid_o}, 32'd0);
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0);
    chk("t6_post_gnt",   {31'b0, bus.dbg_gnt_o}, 32'd0);
    chk("t6_post_stall", {31'b0, bus.stall_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("t6_idle_rvalid_%0d", k), {31'b0, bus.dbg_rvalid_o}, 32'd0);
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
